alu_pipeline: RTL and testbench
===============================

ALU_PIPELINE -- requirements
Module: alu_pipeline

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be >= 4 and a power of two.
REQ-002 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-low.
REQ-004 in_valid_i  input  1  operation request valid.
REQ-005 in_ready_o  output  1  block can accept a request this cycle.
REQ-006 op_i  input  3  opcode: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, SRA=7.
REQ-007 op_a_i, op_b_i  input  WIDTH each  operands A and B.
REQ-008 out_valid_o  output  1  result and flags valid.
REQ-009 out_ready_i  input  1  downstream consumes the result this cycle.
REQ-010 result_o  output  WIDTH  result.
REQ-011 carry_o, zero_o, neg_o, ovf_o  output  1 each  carry/borrow, result==0, result MSB, signed overflow.
REQ-012 op_count_o  output  16  count of results consumed.

Function
REQ-013 Request accepted on clock edge with in_valid_i && in_ready_o; captured into stage-1 register (op, A, B, valid).
REQ-014 Stage 2 SHALL register the combinational result and flags of stage 1; out_valid_o, result_o and flags come directly from stage-2 registers.
REQ-015 Latency: out_valid_o SHALL assert exactly 2 cycles after acceptance when not stalled; throughput one op per cycle.
REQ-016 Stage 2 loads when empty or out_ready_i high; stage 1 loads when empty or stage 2 loads; in_ready_o = !s1_valid || stage-2 load.
REQ-017 While out_valid_o && !out_ready_i, result_o and all flags SHALL remain stable; no request lost, duplicated or reordered.
REQ-018 ADD: {carry,result} = A+B (WIDTH+1 bits); ovf = operand signs equal and differ from result sign.
REQ-019 SUB: result = A-B mod 2^WIDTH; carry = borrow (1 iff A<B unsigned); ovf = operand signs differ and result sign differs from A.
REQ-020 AND/OR/XOR: bitwise; carry=0, ovf=0.
REQ-021 SHL/SHR/SRA: shift A by B[log2(WIDTH)-1:0]; SHR zero-fills, SRA sign-fills; carry=0, ovf=0.
REQ-022 zero = (result==0), neg = result[WIDTH-1], for every opcode.
REQ-023 op_count_o SHALL increment on out_valid_o && out_ready_i, wrapping 0xFFFF -> 0x0000.
REQ-024 Simultaneous consume and new acceptance with pipeline full SHALL advance all stages in the same cycle.

Reset
REQ-025 rst_i low SHALL immediately clear both stage valids, result_o, all flags and op_count_o to 0, independent of clk_i.
REQ-026 In-flight operations at reset SHALL be discarded; in_ready_o SHALL be 1 from the first cycle after rst_i deasserts.

Structure
REQ-027 Package alu_pipeline_pkg SHALL hold the opcode enum (3-bit) and a flags struct {carry, zero, neg, ovf}.
REQ-028 Combinational datapath SHALL be sub-module alu_core (inputs op, A, B; outputs result, flags), parametrised by WIDTH.

Verification (WIDTH=8)
REQ-029 ADD 0xFF+0x01 -> result 0x00, carry=1, zero=1, ovf=0, out_valid 2 cycles after accept.
REQ-030 ADD 0x7F+0x01 -> 0x80, neg=1, ovf=1, carry=0; SUB 0x03-0x05 -> 0xFE, carry=1, neg=1, ovf=0.
REQ-031 SRA 0x80 by 3 -> 0xF0, neg=1; SHR 0x80 by 3 -> 0x10; SHL 0x81 by 9 -> 0x02 (shift uses B mod 8).
REQ-032 Three back-to-back requests with out_ready_i low 5 cycles -> in_ready_o low after 2 accepted, outputs stable, then 3 results drained in order, op_count_o=3.
REQ-033 rst_i asserted mid-cycle while out_valid_o=1 -> out_valid_o and op_count_o 0 before next edge; first post-reset request returns correct result.
REQ-034 Continuous traffic with out_ready_i=1 for 65537 ops -> op_count_o wraps to 0x0001, one result per cycle.

Source files
------------

// File: rtl/alu_pipeline_pkg.sv
// Shared types for the two-stage ALU pipeline: the 3-bit opcode encoding and the
// packed status-flag bundle produced alongside every result.
package alu_pipeline_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_SRA = 3'd7
  } op_t;

  typedef struct packed {
    logic carry;
    logic zero;
    logic neg;
    logic ovf;
  } flags_t;

endpackage

// File: rtl/alu_pipeline_core.sv
// Combinational ALU datapath: result and flags for one operation, zero latency.
// No state and no handshake; the enclosing pipeline registers its outputs.
module alu_core
  import alu_pipeline_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output flags_t           flags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;

  assign sum   = {1'b0, a} + {1'b0, b};
  // The borrow lands in the extra top bit of the widened subtraction.
  assign diff  = {1'b0, a} - {1'b0, b};
  assign shamt = b[SHW-1:0];

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        {carry, res} = sum;
        ovf = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        {carry, res} = diff;
        ovf = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  res = a << shamt;
      OP_SHR:  res = a >> shamt;
      OP_SRA:  res = $unsigned($signed(a) >>> shamt);
      default: res = '0;
    endcase
  end

  assign result      = res;
  assign flags.carry = carry;
  assign flags.zero  = (res == '0);
  assign flags.neg   = res[MSB];
  assign flags.ovf   = ovf;

endmodule

// File: rtl/alu_pipeline.sv
// Two-stage ALU pipeline: operand register, then result/flag register; 2-cycle latency.
// Valid/ready on both sides; a stalled output holds steady and stalls stage 1 behind it.
module alu_pipeline
  import alu_pipeline_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             neg_o,
  output logic             ovf_o,
  output logic [15:0]      op_count_o
);

  logic             s1_valid;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  flags_t           s2_flags;
  logic [15:0]      count;

  logic [WIDTH-1:0] core_result;
  flags_t           core_flags;
  logic             s2_load;

  assign s2_load    = !s2_valid || out_ready_i;
  assign in_ready_o = !s1_valid || s2_load;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (in_ready_o) begin
      s1_valid <= in_valid_i;
      s1_op    <= op_t'(op_i);
      s1_a     <= op_a_i;
      s1_b     <= op_b_i;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .result (core_result),
    .flags  (core_flags)
  );

  // Result data only moves when a real operation arrives, so a drained stage 2 keeps its last value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_flags  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result <= core_result;
        s2_flags  <= core_flags;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count <= '0;
    end else if (s2_valid && out_ready_i) begin
      count <= count + 16'd1;
    end
  end

  assign out_valid_o = s2_valid;
  assign result_o    = s2_result;
  assign carry_o     = s2_flags.carry;
  assign zero_o      = s2_flags.zero;
  assign neg_o       = s2_flags.neg;
  assign ovf_o       = s2_flags.ovf;
  assign op_count_o  = count;

endmodule

// File: tb/tb_alu_pipeline.sv
// Directed bench for alu_pipeline (WIDTH=8) with hand-computed expected values.
module tb_alu_pipeline;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  op_i;
  logic [7:0]  op_a_i;
  logic [7:0]  op_b_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [7:0]  result_o;
  logic        carry_o;
  logic        zero_o;
  logic        neg_o;
  logic        ovf_o;
  logic [15:0] op_count_o;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_count = 0;

  always #5 clk_i = ~clk_i;

  alu_pipeline #(.WIDTH(8)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .op_i        (op_i),
    .op_a_i      (op_a_i),
    .op_b_i      (op_b_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .carry_o     (carry_o),
    .zero_o      (zero_o),
    .neg_o       (neg_o),
    .ovf_o       (ovf_o),
    .op_count_o  (op_count_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [3:0] flags_now();
    return {carry_o, zero_o, neg_o, ovf_o};
  endfunction

  // Flags are compared as {carry, zero, neg, ovf}.
  task automatic single_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp_res, input logic [3:0] exp_flags);
    in_valid_i = 1'b1;
    op_i = op;
    op_a_i = a;
    op_b_i = b;
    step();
    in_valid_i = 1'b0;
    check({tag, "_lat1"}, {31'd0, out_valid_o}, 32'd0);
    step();
    check({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
    check({tag, "_result"}, {24'd0, result_o}, {24'd0, exp_res});
    check({tag, "_flags"}, {28'd0, flags_now()}, {28'd0, exp_flags});
    step();
    exp_count++;
    check({tag, "_count"}, {16'd0, op_count_o}, exp_count);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    #1;
    step();
    rst_i = 1'b1;
    step();
    exp_count = 0;
  endtask

  initial begin
    int recv;
    int stalls;
    int bad;
    int gaps;
    int cycles;

    rst_i = 1'b0;
    in_valid_i = 1'b0;
    op_i = 3'd0;
    op_a_i = 8'd0;
    op_b_i = 8'd0;
    out_ready_i = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_result", {24'd0, result_o}, 32'd0);
    check("rst_flags", {28'd0, flags_now()}, 32'd0);
    check("rst_count", {16'd0, op_count_o}, 32'd0);
    step();
    rst_i = 1'b1;
    step();
    check("post_rst_in_ready", {31'd0, in_ready_o}, 32'd1);

    single_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 8'h00, 4'b1100);
    single_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 8'h80, 4'b0011);
    single_op("sub_03_05", 3'd1, 8'h03, 8'h05, 8'hFE, 4'b1010);
    single_op("sub_80_01", 3'd1, 8'h80, 8'h01, 8'h7F, 4'b0001);
    single_op("and_f0_3c", 3'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    single_op("or_80_01",  3'd3, 8'h80, 8'h01, 8'h81, 4'b0010);
    single_op("xor_aa_aa", 3'd4, 8'hAA, 8'hAA, 8'h00, 4'b0100);
    single_op("sra_80_3",  3'd7, 8'h80, 8'h03, 8'hF0, 4'b0010);
    single_op("shr_80_3",  3'd6, 8'h80, 8'h03, 8'h10, 4'b0000);
    single_op("shl_81_9",  3'd5, 8'h81, 8'h09, 8'h02, 4'b0000);

    // Backpressure: three back-to-back requests against a stalled output.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    op_i = 3'd0; op_a_i = 8'h01; op_b_i = 8'h01;
    check("bp_ready0", {31'd0, in_ready_o}, 32'd1);
    step();
    check("bp_ready1", {31'd0, in_ready_o}, 32'd1);
    op_a_i = 8'h02; op_b_i = 8'h02;
    step();
    check("bp_ready2", {31'd0, in_ready_o}, 32'd0);
    op_a_i = 8'h03; op_b_i = 8'h03;
    for (int i = 0; i < 4; i++) begin
      step();
      check("bp_stall_ready", {31'd0, in_ready_o}, 32'd0);
      check("bp_stall_valid", {31'd0, out_valid_o}, 32'd1);
      check("bp_stall_result", {24'd0, result_o}, 32'h02);
      check("bp_stall_count", {16'd0, op_count_o}, exp_count);
    end
    out_ready_i = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, in_ready_o}, 32'd1);
    step();
    in_valid_i = 1'b0;
    check("bp_drain2", {24'd0, result_o}, 32'h04);
    step();
    check("bp_drain3", {24'd0, result_o}, 32'h06);
    check("bp_drain3_valid", {31'd0, out_valid_o}, 32'd1);
    step();
    exp_count += 3;
    check("bp_empty", {31'd0, out_valid_o}, 32'd0);
    check("bp_count", {16'd0, op_count_o}, exp_count);

    // Asynchronous reset while a result is held at the output.
    out_ready_i = 1'b0;
    in_valid_i = 1'b1;
    op_i = 3'd0; op_a_i = 8'h10; op_b_i = 8'h20;
    step();
    in_valid_i = 1'b0;
    step();
    check("ar_pre_valid", {31'd0, out_valid_o}, 32'd1);
    #2;
    rst_i = 1'b0;
    #1;
    check("ar_valid", {31'd0, out_valid_o}, 32'd0);
    check("ar_count", {16'd0, op_count_o}, 32'd0);
    check("ar_result", {24'd0, result_o}, 32'd0);
    step();
    rst_i = 1'b1;
    out_ready_i = 1'b1;
    exp_count = 0;
    step();
    check("ar_in_ready", {31'd0, in_ready_o}, 32'd1);
    check("ar_discarded", {31'd0, out_valid_o}, 32'd0);
    single_op("ar_add_05_06", 3'd0, 8'h05, 8'h06, 8'h0B, 4'b0000);

    // Streaming: 65537 ADDs of (i, 1) with the output always ready.
    do_reset();
    recv = 0; stalls = 0; bad = 0; gaps = 0; cycles = 0;
    op_i = 3'd0;
    op_b_i = 8'h01;
    while (recv < 65537 && cycles < 65600) begin
      if (cycles < 65537) begin
        in_valid_i = 1'b1;
        op_a_i = cycles[7:0];
      end else begin
        in_valid_i = 1'b0;
      end
      if (!in_ready_o) stalls++;
      step();
      cycles++;
      if (out_valid_o) begin
        if (result_o !== 8'(recv + 1)) bad++;
        recv++;
      end else if (recv > 0) begin
        gaps++;
      end
    end
    in_valid_i = 1'b0;
    step();
    check("stream_received", recv, 32'd65537);
    check("stream_bad_results", bad, 32'd0);
    check("stream_stalls", stalls, 32'd0);
    check("stream_gaps", gaps, 32'd0);
    check("stream_cycles", cycles, 32'd65538);
    check("stream_count_wrap", {16'd0, op_count_o}, 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
